// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and uart_tx.
//   state_t      : receiver/transmitter FSM states, fixed 2-bit encoding
//   DATA_BITS    : payload bits per frame (8N1)
//   OVS_DEFAULT  : default oversampling ratio (sample_tick pulses per bit)
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned OVS_DEFAULT = 16;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk       : destination clock
//   rst_n     : asynchronous active-low reset; both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronized output
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by an external sample_tick.
//   CLK         : system clock
//   rst_n       : asynchronous active-low reset
//   sample_tick : one-CLK enable at OVS x baud from the shared baud generator
//   RX          : serial line, idle high, asynchronous to CLK
//   data_out    : last correctly framed byte, held until the next good frame
//   valid_out   : one-CLK pulse when data_out updates
//   frame_err   : one-CLK pulse when the stop bit samples low
//   busy        : high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVS = OVS_DEFAULT
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW = $clog2(OVS);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVS - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_sync;
  logic                 rx_prev;
  state_t               state,    state_nx;
  logic [TW-1:0]        tick_cnt, tick_nx;
  logic [2:0]           bit_idx,  bit_nx;
  logic [DATA_BITS-1:0] shreg,    shreg_nx;
  logic [7:0]           data_nx;
  logic                 valid_nx, ferr_nx;

  uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (CLK),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_sync)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_nx;
      bit_idx   <= bit_nx;
      shreg     <= shreg_nx;
      data_out  <= data_nx;
      valid_out <= valid_nx;
      frame_err <= ferr_nx;
      if (sample_tick) begin
        rx_prev <= rx_sync;
      end
    end
  end

  // Everything except the output pulses is gated by sample_tick; the pulses
  // are produced on the tick that samples the stop bit and clear on the
  // following CLK because their default is 0.
  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    data_nx  = data_out;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    if (sample_tick) begin
      case (state)
        S_IDLE: begin
          // Edge detect, not level: a held-low line never starts a frame.
          if (!rx_sync && rx_prev) begin
            state_nx = S_START;
            tick_nx  = '0;
          end
        end
        S_START: begin
          if (tick_cnt == MID_TICK) begin
            tick_nx = '0;
            if (!rx_sync) begin
              state_nx = S_DATA;
              bit_nx   = '0;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt == LAST_TICK) begin
            shreg_nx = {rx_sync, shreg[DATA_BITS-1:1]};
            tick_nx  = '0;
            if (bit_idx == LAST_BIT) begin
              state_nx = S_STOP;
            end else begin
              bit_nx = bit_idx + 3'd1;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop lets the next start edge be caught at once.
          if (tick_cnt == LAST_TICK) begin
            tick_nx  = '0;
            state_nx = S_IDLE;
            if (rx_sync) begin
              data_nx  = shreg;
              valid_nx = 1'b1;
            end else begin
              ferr_nx = 1'b1;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          tick_nx  = '0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at OVS=16, sample_tick every 4 CLKs
// (64 CLKs per nominal bit).
module tb_uart_rx;

  localparam int unsigned NOM_BIT = 64;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       sample_tick = 1'b0;
  logic       RX;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  exp_t       expq[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.OVS(16)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .RX          (RX),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    int unsigned cnt = 0;
    forever begin
      @(negedge CLK);
      sample_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a good stop bit yields the byte; a bad one yields a frame error
  // with data_out still showing the last good byte.
  task automatic expect_frame(input logic [7:0] d, input bit good);
    exp_t e;
    if (good) begin
      last_good = d;
      e.is_err  = 1'b0;
      e.data    = d;
    end else begin
      e.is_err  = 1'b1;
      e.data    = last_good;
    end
    expq.push_back(e);
  endtask

  task automatic drive(input logic v, input int unsigned clks);
    RX = v;
    repeat (clks) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned bc,
                            input int unsigned idle_bits);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(bits[i], bc);
      if (i == 0) check("busy_in_frame", {31'b0, busy}, 32'd1);
    end
    if (idle_bits > 0) drive(1'b1, idle_bits * bc);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (expq.size() != 0 && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    check("queue_drained", expq.size(), 32'd0);
  endtask

  // Monitor: pops one expectation per output pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (valid_out || frame_err) begin
        check("pulse_exclusive", {31'b0, valid_out & frame_err}, 32'd0);
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse valid_out=%0b frame_err=%0b required=none at %0t",
                   valid_out, frame_err, $time);
        end else begin
          e = expq.pop_front();
          check("pulse_is_frame_err", {31'b0, frame_err}, {31'b0, e.is_err});
          check("data_out", {24'b0, data_out}, {24'b0, e.data});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout queue=%0d", expq.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int         e;
    bit         good;
    int unsigned idle;
    logic [7:0] v5a;

    RX    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst_data_out", {24'b0, data_out}, 32'h0);
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 2 * NOM_BIT);

    // Single good frame
    expect_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, NOM_BIT, 2);
    wait_drain();

    // Start-bit glitch of 4 sample ticks
    drive(1'b0, 16);
    drive(1'b1, 3 * NOM_BIT);
    check("glitch_busy", {31'b0, busy}, 32'd0);
    check("glitch_data_out", {24'b0, data_out}, {24'b0, last_good});

    // Bad stop bit, then a long break
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, NOM_BIT, 0);
    drive(1'b0, 30 * NOM_BIT);
    check("break_busy", {31'b0, busy}, 32'd0);
    check("break_data_out", {24'b0, data_out}, {24'b0, last_good});
    drive(1'b1, 2 * NOM_BIT);
    wait_drain();

    // Back-to-back frames, no idle gap
    expect_frame(8'h00, 1'b1);
    expect_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1, NOM_BIT, 0);
    send_frame(8'hFF, 1'b1, NOM_BIT, 2);
    wait_drain();

    // Reset during data bit 4 of 0x5A
    v5a = 8'h5A;
    drive(1'b0, NOM_BIT);
    for (int i = 0; i < 4; i++) drive(v5a[i], NOM_BIT);
    drive(v5a[4], NOM_BIT / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", {24'b0, data_out}, 32'h0);
    check("midrst_valid_out", {31'b0, valid_out}, 32'd0);
    check("midrst_frame_err", {31'b0, frame_err}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    last_good = 8'h00;
    drive(1'b1, 5);
    rst_n = 1'b1;
    drive(1'b1, 2 * NOM_BIT);
    check("postrst_busy", {31'b0, busy}, 32'd0);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, NOM_BIT, 2);
    wait_drain();

    // Baud error sweep, -3% .. +3%
    for (int pct = -3; pct <= 3; pct++) begin
      expect_frame(8'h55, 1'b1);
      send_frame(8'h55, 1'b1, (NOM_BIT * (100 + pct)) / 100, 1);
    end
    wait_drain();

    // Random frames: random data, baud error, stop-bit fault and gap
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      e    = int'($urandom_range(6)) - 3;
      good = ($urandom_range(9) < 8);
      idle = $urandom_range(2);
      if (!good && idle == 0) idle = 1;
      expect_frame(d, good);
      send_frame(d, good ? 1'b1 : 1'b0, (NOM_BIT * (100 + e)) / 100, idle);
    end
    drive(1'b1, 2 * NOM_BIT);
    wait_drain();
    check("final_data_out", {24'b0, data_out}, {24'b0, last_good});
    check("final_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
